// File: rtl/deser_pkg.sv
// Shared types and constants for the serial receiver family.
// The collector state type is reused by any receiver that gathers bits into words.
package deser_pkg;

   typedef enum logic {IDLE, SHIFT} state_t;

   localparam int DESER_W = 8;

endpackage

// File: rtl/deser_outbuf.sv
// One-entry holding register with a valid/ready output port.
// A load that arrives while a word is still held (and not being taken) is dropped and flagged.
module deser_outbuf
   import deser_pkg::*;
#(
   parameter int W = DESER_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_data,
   input  logic         out_ready,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   output logic         overrun
);

   // Handshake: a word transfers on any rising edge where out_valid && out_ready.
   // out_data is held stable while out_valid && !out_ready, and a new word may be
   // loaded in the same cycle the old one transfers, so no bubble is inserted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         overrun   <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (load) begin
            if (!out_valid || out_ready) begin
               out_data  <= load_data;
               out_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/deser8.sv
// Serial-to-parallel receiver: gathers N bits LSB first after a start marker and
// hands complete words to a one-entry valid/ready output buffer.
module deser8
   import deser_pkg::*;
#(
   parameter int N  = DESER_W,
   parameter int IW = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         in_valid,
   input  logic         in_bit,
   input  logic         out_ready,
   output logic         out_valid,
   output logic [N-1:0] out_data,
   output logic         overrun,
   output logic         sync_err
);

   state_t        state, state_n;
   logic [IW-1:0] idx, idx_n;
   logic [N-2:0]  sreg, sreg_n;
   logic          sync_n;
   logic          load;
   logic [N-1:0]  load_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         idx      <= '0;
         sreg     <= '0;
         sync_err <= 1'b0;
      end else begin
         state    <= state_n;
         idx      <= idx_n;
         sreg     <= sreg_n;
         sync_err <= sync_n;
      end
   end

   always_comb begin
      state_n   = state;
      idx_n     = idx;
      sreg_n    = sreg;
      sync_n    = 1'b0;
      load      = 1'b0;
      load_data = {in_bit, sreg};
      unique case (state)
         IDLE: begin
            if (in_valid && start) begin
               sreg_n[0] = in_bit;
               idx_n     = IW'(1);
               state_n   = SHIFT;
            end
         end
         SHIFT: begin
            if (in_valid && start) begin
               // Resync: the partial word is abandoned and this bit becomes bit 0.
               sreg_n[0] = in_bit;
               idx_n     = IW'(1);
               sync_n    = 1'b1;
            end else if (in_valid && (idx == IW'(N-1))) begin
               load    = 1'b1;
               idx_n   = '0;
               state_n = IDLE;
            end else if (in_valid) begin
               for (int i = 0; i < N-1; i++) begin
                  if (idx == IW'(i)) sreg_n[i] = in_bit;
               end
               idx_n = idx + IW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   deser_outbuf #(.W(N)) u_outbuf (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .load_data (load_data),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .overrun   (overrun)
   );

endmodule

// File: tb/tb_deser8.sv
// Bench for deser8: directed scenarios with constant expectations, then a long
// randomized run against a bit-list reference model and an output word scoreboard.
module tb_deser8;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_bit = 1'b0;
   logic         out_ready = 1'b0;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic         overrun;
   logic         sync_err;

   int passed = 0;
   int total  = 0;

   // observation counters, cleared by the tests that use them
   int ovr_cnt  = 0;
   int sync_cnt = 0;
   int vcnt     = 0;
   logic [W-1:0] acc_q[$];

   // reference model: bits received since the last start, plus the held word
   logic         mbits[$];
   logic [W-1:0] md;
   logic         mv, movr, msync;
   logic [W-1:0] exp_q[$];

   always #5 clk = ~clk;

   deser8 #(.N(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .in_valid  (in_valid),
      .in_bit    (in_bit),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .overrun   (overrun),
      .sync_err  (sync_err)
   );

   task automatic model_reset();
      mbits.delete();
      exp_q.delete();
      md    = '0;
      mv    = 1'b0;
      movr  = 1'b0;
      msync = 1'b0;
   endtask

   task automatic model_update(input logic s, input logic v, input logic b, input logic r);
      logic         completed;
      logic [W-1:0] word;
      logic         sy;
      completed = 1'b0;
      word      = '0;
      sy        = 1'b0;
      if (v) begin
         if (s) begin
            if (mbits.size() != 0) sy = 1'b1;
            mbits.delete();
            mbits.push_back(b);
         end else if (mbits.size() != 0) begin
            mbits.push_back(b);
            if (mbits.size() == W) begin
               for (int i = 0; i < W; i++) word[i] = mbits[i];
               completed = 1'b1;
               mbits.delete();
            end
         end
      end
      movr = 1'b0;
      if (completed) begin
         if (!mv || r) begin
            md = word;
            mv = 1'b1;
            exp_q.push_back(word);
         end else begin
            movr = 1'b1;
         end
      end else if (mv && r) begin
         mv = 1'b0;
      end
      msync = sy;
   endtask

   // drive one cycle of inputs, advance one clock, sample #1 after the edge
   task automatic step(input logic s, input logic v, input logic b, input logic r);
      start     = s;
      in_valid  = v;
      in_bit    = b;
      out_ready = r;
      if (out_valid && out_ready) acc_q.push_back(out_data);
      model_update(s, v, b, r);
      @(posedge clk);
      #1;
      ovr_cnt  += int'(overrun);
      sync_cnt += int'(sync_err);
      vcnt     += int'(out_valid);
   endtask

   task automatic send_word(input logic [W-1:0] w, input logic r);
      for (int i = 0; i < W; i++) step(i == 0, 1'b1, w[i], r);
   endtask

   task automatic do_reset();
      start = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
      rst = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      total++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", out_valid); else passed++;
      total++; if (out_data !== 8'h00) $display("FAIL rst_data: got %h want 00", out_data); else passed++;
      total++; if (overrun !== 1'b0) $display("FAIL rst_overrun: got %b want 0", overrun); else passed++;
      total++; if (sync_err !== 1'b0) $display("FAIL rst_sync: got %b want 0", sync_err); else passed++;
      rst = 1'b0;
      send_word(8'hFF, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      total++; if (out_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", out_valid); else passed++;
      total++; if (out_data !== 8'h00) $display("FAIL midrst_data: got %h want 00", out_data); else passed++;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sync_cnt = 0;
      send_word(8'hA5, 1'b0);
      total++; if (out_valid !== 1'b1) $display("FAIL postrst_valid: got %b want 1", out_valid); else passed++;
      total++; if (out_data !== 8'hA5) $display("FAIL postrst_data: got %h want a5", out_data); else passed++;
      total++; if (sync_cnt !== 0) $display("FAIL postrst_sync: got %0d pulses want 0", sync_cnt); else passed++;
   endtask

   task automatic test_basic();
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      total++; if (out_valid !== 1'b0) $display("FAIL idle_ignore_valid: got %b want 0", out_valid); else passed++;
      vcnt = 0;
      sync_cnt = 0;
      send_word(8'hA5, 1'b1);
      total++; if (out_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", out_valid); else passed++;
      total++; if (out_data !== 8'hA5) $display("FAIL basic_data: got %h want a5", out_data); else passed++;
      step(1'b0, 1'b0, 1'b0, 1'b1);
      total++; if (out_valid !== 1'b0) $display("FAIL basic_consumed: got %b want 0", out_valid); else passed++;
      total++; if (vcnt !== 1) $display("FAIL basic_valid_cycles: got %0d want 1", vcnt); else passed++;
      total++; if (sync_cnt !== 0) $display("FAIL basic_sync: got %0d want 0", sync_cnt); else passed++;
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] a;
      logic [W-1:0] c;
      a = 8'h3C;
      c = 8'hC3;
      acc_q.delete();
      for (int i = 0; i < W; i++) begin
         step(i == 0, 1'b1, a[i], 1'b1);
         if (i < W-1) step(1'b0, 1'b0, 1'b0, 1'b1);
      end
      send_word(c, 1'b1);
      repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1);
      total++; if (acc_q.size() !== 2) $display("FAIL b2b_count: got %0d want 2", acc_q.size());
      else begin
         passed++;
         total++; if (acc_q[0] !== 8'h3C) $display("FAIL b2b_first: got %h want 3c", acc_q[0]); else passed++;
         total++; if (acc_q[1] !== 8'hC3) $display("FAIL b2b_second: got %h want c3", acc_q[1]); else passed++;
      end
   endtask

   task automatic test_backpressure();
      ovr_cnt = 0;
      send_word(8'h11, 1'b0);
      send_word(8'h22, 1'b0);
      total++; if (overrun !== 1'b1) $display("FAIL bp_overrun: got %b want 1", overrun); else passed++;
      total++; if (out_data !== 8'h11) $display("FAIL bp_data: got %h want 11", out_data); else passed++;
      step(1'b0, 1'b0, 1'b0, 1'b0);
      total++; if (overrun !== 1'b0) $display("FAIL bp_overrun_pulse: got %b want 0", overrun); else passed++;
      total++; if (ovr_cnt !== 1) $display("FAIL bp_overrun_count: got %0d want 1", ovr_cnt); else passed++;
      acc_q.delete();
      step(1'b0, 1'b0, 1'b0, 1'b1);
      total++; if (out_valid !== 1'b0) $display("FAIL bp_drained: got %b want 0", out_valid); else passed++;
      total++; if (acc_q.size() != 1 || acc_q[0] !== 8'h11)
         $display("FAIL bp_accepted: got %0d words want one word 11", acc_q.size());
      else passed++;
   endtask

   task automatic test_resync();
      logic [W-1:0] w;
      w = 8'h5A;
      sync_cnt = 0;
      step(1'b1, 1'b1, 1'b1, 1'b1);
      repeat (3) step(1'b0, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < W; i++) begin
         step(i == 0, 1'b1, w[i], 1'b1);
         if (i == 0) begin
            total++; if (sync_err !== 1'b1) $display("FAIL resync_pulse: got %b want 1", sync_err); else passed++;
         end
      end
      total++; if (out_valid !== 1'b1) $display("FAIL resync_valid: got %b want 1", out_valid); else passed++;
      total++; if (out_data !== 8'h5A) $display("FAIL resync_data: got %h want 5a", out_data); else passed++;
      step(1'b0, 1'b0, 1'b0, 1'b1);
      total++; if (sync_cnt !== 1) $display("FAIL resync_count: got %0d want 1", sync_cnt); else passed++;
   endtask

   task automatic test_simultaneous();
      logic [W-1:0] w;
      w = 8'h02;
      send_word(8'h01, 1'b0);
      total++; if (out_data !== 8'h01) $display("FAIL simul_hold: got %h want 01", out_data); else passed++;
      for (int i = 0; i < W; i++) step(i == 0, 1'b1, w[i], i == W-1);
      total++; if (out_valid !== 1'b1) $display("FAIL simul_valid: got %b want 1", out_valid); else passed++;
      total++; if (out_data !== 8'h02) $display("FAIL simul_data: got %h want 02", out_data); else passed++;
      total++; if (overrun !== 1'b0) $display("FAIL simul_overrun: got %b want 0", overrun); else passed++;
      step(1'b0, 1'b0, 1'b0, 1'b1);
      total++; if (out_valid !== 1'b0) $display("FAIL simul_drain: got %b want 0", out_valid); else passed++;
   endtask

   task automatic test_random();
      logic         s, v, b, r;
      logic [W-1:0] w;
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 599) == 0) do_reset();
         s = ($urandom_range(0, 9) == 0);
         v = ($urandom_range(0, 3) != 0);
         b = 1'($urandom_range(0, 1));
         r = ($urandom_range(0, 2) != 0);
         if (out_valid && r) begin
            total++;
            if (exp_q.size() == 0) $display("FAIL rnd_unexpected_word: got %h want no word", out_data);
            else begin
               w = exp_q.pop_front();
               if (out_data !== w) $display("FAIL rnd_word: got %h want %h", out_data, w); else passed++;
            end
         end
         step(s, v, b, r);
         total++; if (out_valid !== mv) $display("FAIL rnd_valid: got %b want %b", out_valid, mv); else passed++;
         total++; if (out_data !== md) $display("FAIL rnd_data: got %h want %h", out_data, md); else passed++;
         total++; if (overrun !== movr) $display("FAIL rnd_overrun: got %b want %b", overrun, movr); else passed++;
         total++; if (sync_err !== msync) $display("FAIL rnd_sync: got %b want %b", sync_err, msync); else passed++;
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic();
      test_back_to_back();
      test_backpressure();
      test_resync();
      test_simultaneous();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
